// File: rtl/axi4_rd_dbi_concat_if.sv
// AXI4 read-channel and DBI RX PHY byte-stream bundle for axi4_rd_dbi_concat.
// The slave modport is the read front end; the master modport is the
// interconnect/PHY side that drives requests and bytes.
interface axi4_rd_dbi_concat_if #(
   parameter int DATA_W           = 256,
   parameter int ADDR_W           = 32,
   parameter int MST_ID_W         = 5,
   parameter int TRANS_DATA_LEN_W = 8,
   parameter int TRANS_RESP_W     = 2,
   parameter int DBI_IF_D_W       = 8
);
   logic [MST_ID_W-1:0]         m_arid_i;
   logic [ADDR_W-1:0]           m_araddr_i;
   logic [TRANS_DATA_LEN_W-1:0] m_arlen_i;
   logic                        m_arvalid_i;
   logic                        m_arready_o;
   logic [MST_ID_W-1:0]         m_rid_o;
   logic [DATA_W-1:0]           m_rdata_o;
   logic [TRANS_RESP_W-1:0]     m_rresp_o;
   logic                        m_rlast_o;
   logic                        m_rvalid_o;
   logic                        m_rready_i;
   logic [DBI_IF_D_W-1:0]       drp_d_data_i;
   logic                        drp_d_vld_i;
   logic                        drp_d_rdy_o;

   modport slave (
      input  m_arid_i, m_araddr_i, m_arlen_i, m_arvalid_i, m_rready_i,
      input  drp_d_data_i, drp_d_vld_i,
      output m_arready_o, m_rid_o, m_rdata_o, m_rresp_o, m_rlast_o, m_rvalid_o,
      output drp_d_rdy_o
   );

   modport master (
      output m_arid_i, m_araddr_i, m_arlen_i, m_arvalid_i, m_rready_i,
      output drp_d_data_i, drp_d_vld_i,
      input  m_arready_o, m_rid_o, m_rdata_o, m_rresp_o, m_rlast_o, m_rvalid_o,
      input  drp_d_rdy_o
   );
endinterface

// File: rtl/axi4_rd_dbi_concat.sv
// AXI4 read-slave front end for the display RX path. One burst at a time on a
// single mapped address: PHY bytes are packed LSB-first into DATA_W words,
// buffered in a small word FIFO and returned as R beats. Any other address is
// answered with DECERR beats and never touches the PHY.
module axi4_rd_dbi_concat #(
   parameter int                DATA_W           = 256,
   parameter int                ADDR_W           = 32,
   parameter int                MST_ID_W         = 5,
   parameter int                TRANS_DATA_LEN_W = 8,
   parameter int                TRANS_RESP_W     = 2,
   parameter logic [ADDR_W-1:0] BASE_ADDR        = 32'h2000_0000,
   parameter int                DBI_IF_D_W       = 8,
   parameter int                R_FIFO_CAPAC     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   axi4_rd_dbi_concat_if.slave       bus
);
   localparam int BPW   = DATA_W / DBI_IF_D_W;
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int PTR_W = (R_FIFO_CAPAC > 1) ? $clog2(R_FIFO_CAPAC) : 1;
   localparam int CNT_W = $clog2(R_FIFO_CAPAC + 1);
   localparam int LEN_W = TRANS_DATA_LEN_W;

   typedef enum logic [1:0] {IDLE, RD_OK, RD_ERR} state_t;

   state_t                 state_q, state_d;
   logic [MST_ID_W-1:0]    id_q;
   logic [LEN_W-1:0]       len_q;
   logic [LEN_W-1:0]       beat_cnt_q;
   logic [LEN_W:0]         words_pushed_q;   // one extra bit: len=255 needs 256
   logic [IDX_W-1:0]       idx_q;
   logic [DATA_W-1:0]      asm_q;
   logic [DATA_W-1:0]      mem [R_FIFO_CAPAC];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q;

   logic                   ar_hs, r_hs, byte_rdy, byte_hs, push, pop;
   logic                   fifo_full, fifo_empty, idx_last;
   logic                   rvalid, rlast;
   logic [TRANS_RESP_W-1:0] rresp;
   logic [MST_ID_W-1:0]    rid;
   logic [DATA_W-1:0]      rdata, word_in;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(R_FIFO_CAPAC - 1)) ? '0 : p + 1'b1;
   endfunction

   assign fifo_full  = (count_q == CNT_W'(R_FIFO_CAPAC));
   assign fifo_empty = (count_q == '0);
   assign idx_last   = (idx_q == IDX_W'(BPW - 1));
   assign ar_hs      = (state_q == IDLE) & bus.m_arvalid_i;
   // Stop fetching once the burst's words are all taken, and never take a
   // word-completing byte that the FIFO could not absorb.
   assign byte_rdy   = (state_q == RD_OK) & (words_pushed_q <= {1'b0, len_q})
                       & ~(idx_last & fifo_full);
   assign byte_hs    = byte_rdy & bus.drp_d_vld_i;
   assign push       = byte_hs & idx_last;
   assign r_hs       = rvalid & bus.m_rready_i;
   assign pop        = r_hs & (state_q == RD_OK);

   // Merge the incoming byte into the partial word so a completing byte can
   // be written to the FIFO on the same edge it is accepted.
   always_comb begin
      word_in = asm_q;
      word_in[idx_q*DBI_IF_D_W +: DBI_IF_D_W] = bus.drp_d_data_i;
   end

   // Next-state and R channel outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d = state_q;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = '0;
      rid     = '0;
      case (state_q)
         IDLE: begin
            if (bus.m_arvalid_i)
               state_d = (bus.m_araddr_i == BASE_ADDR) ? RD_OK : RD_ERR;
         end
         RD_OK: begin
            rvalid = ~fifo_empty;
            rdata  = mem[rd_ptr_q];
            rid    = id_q;
         end
         RD_ERR: begin
            rvalid = 1'b1;
            rresp  = 2'b11;
            rid    = id_q;
         end
         default: state_d = IDLE;
      endcase
      rlast = rvalid & (beat_cnt_q == len_q);
      if ((state_q != IDLE) && r_hs && rlast)
         state_d = IDLE;
   end

   assign bus.m_arready_o = (state_q == IDLE);
   assign bus.m_rvalid_o  = rvalid;
   assign bus.m_rdata_o   = rdata;
   assign bus.m_rresp_o   = rresp;
   assign bus.m_rid_o     = rid;
   assign bus.m_rlast_o   = rlast;
   assign bus.drp_d_rdy_o = byte_rdy;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Request capture, burst counters, byte assembler and FIFO bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_q           <= '0;
         len_q          <= '0;
         beat_cnt_q     <= '0;
         words_pushed_q <= '0;
         idx_q          <= '0;
         asm_q          <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
      end else begin
         if (ar_hs) begin
            id_q           <= bus.m_arid_i;
            len_q          <= bus.m_arlen_i;
            beat_cnt_q     <= '0;
            words_pushed_q <= '0;
            idx_q          <= '0;
            asm_q          <= '0;
         end
         if (byte_hs) begin
            if (idx_last) begin
               idx_q          <= '0;
               asm_q          <= '0;
               words_pushed_q <= words_pushed_q + 1'b1;
            end else begin
               idx_q <= idx_q + 1'b1;
               asm_q <= word_in;
            end
         end
         if (r_hs)
            beat_cnt_q <= beat_cnt_q + 1'b1;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Word storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; occupancy is tracked by the reset
      // pointers and count, and the data output is gated outside RD_OK.
      if (push) mem[wr_ptr_q] <= word_in;
   end
endmodule
